fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops DATASIZEL-bit entries through the FIFO's rinc/rdata/rempty port and packs WORD_BYTES consecutive entries, little-endian, into one wide word. The word is presented on a valid/ready output stream. A flush input emits a partially filled word with a lane-keep mask, so downstream logic can drain the FIFO completely.

Parameters:
DATASIZEL, 8, width of one FIFO entry; must match the FIFO instance.
WORD_BYTES, 4, number of FIFO entries packed per output word; legal range 2..8.
CNTW, 16, width of the output word counter.

Ports:
rclk  input  1  read-domain clock; the only clock of this block.
rrst_n  input  1  asynchronous active-low reset.
rempty  input  1  FIFO empty flag.
rdata  input  DATASIZEL  FIFO read data; valid combinationally whenever rempty=0.
rinc  output  1  FIFO pop strobe; combinational.
flush  input  1  request to emit the current partial word; sampled every rclk edge.
out_valid  output  1  output word valid.
out_ready  input  1  downstream accept.
out_data  output  DATASIZEL*WORD_BYTES  packed word; entry k sits at bits [k*DATASIZEL +: DATASIZEL].
out_keep  output  WORD_BYTES  bit k=1 means lane k holds a popped entry.
word_cnt  output  CNTW  count of accepted output words; wraps modulo 2^CNTW.

Behaviour:
- Interface: one clock, rclk; reset rrst_n is asynchronous and active-low.
- Reset values: FSM=FILL, lane index idx=0, out_valid=0, out_data=0, out_keep=0, word_cnt=0. rinc is combinational, so it equals (!rempty) immediately after reset.
- Reset mid-operation: entries already popped but not yet delivered are discarded. No recovery is attempted.
- FSM has two states, FILL and HOLD.
- FILL:
  - rinc = !rempty, combinationally.
  - On each rclk edge with rinc=1: rdata is written into lane idx, keep[idx] is set, and idx increments.
  - If idx==WORD_BYTES-1 at that pop, the word is complete: next state HOLD, out_valid=1 from the following cycle, idx returns to 0.
  - If flush=1 at a clock edge in FILL: lanes filled so far, plus any lane popped in that same cycle, form the word. If at least one lane is filled, go to HOLD.
  - Flush with no filled lanes and no simultaneous pop is ignored; no zero-keep word is ever emitted.
  - Unfilled lanes of out_data read as 0.
- HOLD:
  - rinc=0 regardless of rempty; no pops occur.
  - out_valid=1; out_data and out_keep are held stable until accepted.
  - flush is ignored.
  - On an edge with out_ready=1: word_cnt increments, out_valid=0, out_data=0, out_keep=0, next state FILL.
  - The next pop can occur no earlier than the cycle after acceptance.
- Throughput: at best one word per WORD_BYTES+1 cycles; the one-cycle bubble after each word is required.
- rinc is never asserted while rempty=1, so the FIFO is never underflowed.
- out_valid never deasserts without a handshake.
- out_ready is a don't-care while out_valid=0.
- word_cnt wraps from 2^CNTW-1 to 0 without any flag.

Test Plan:
1. Basic pack, WORD_BYTES=4: FIFO holds 0x11,0x22,0x33,0x44 and out_ready=1 -> rinc is high for 4 consecutive cycles. out_valid rises the cycle after the 4th pop with out_data=0x44332211 and out_keep=4'b1111. word_cnt reads 1 after the handshake.
2. Backpressure: FIFO holds 0x11..0x88 and out_ready=0 -> after 4 pops rinc stays 0 while rempty=0, and out_data=0x44332211 stays stable. Raising out_ready yields a second word 0x88776655 with word_cnt=2.
3. Partial flush: pops 0xA1,0xA2, then rempty=1 and a one-cycle flush -> out_data=0x0000A2A1, out_keep=4'b0011.
4. Flush edge cases:
   - Flush with idx=0 and rempty=1 -> no out_valid.
   - Flush in the same cycle as the 3rd pop (bytes 0x01,0x02,0x03) -> out_data=0x00030201, out_keep=4'b0111.
5. Reset mid-fill: after 2 pops, assert rrst_n=0 asynchronously -> all outputs return to reset values immediately. The next 0xB1..0xB4 produce exactly 0xB4B3B2B1 with keep 4'b1111.
6. Sparse FIFO: rempty alternates 0/1 every cycle with data 0xC1..0xC4 -> rinc is asserted only in cycles where rempty=0, never when rempty=1, and the word is 0xC4C3C2C1. Also preload word_cnt to 0xFFFF and check it wraps to 0 on the next accepted word.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Bundles the FIFO read port and the packed-word output stream of
// fifo_rd_packer.
//   rempty/rdata/rinc : FIFO read side (empty flag, head entry, pop strobe)
//   flush             : request to emit the current partial word
//   out_valid/out_ready/out_data/out_keep : packed-word valid/ready stream
// Modport master is the packer's view; slave is the environment's view
// (the FIFO plus the downstream consumer).
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
   parameter int DATASIZEL  = 8,
   parameter int WORD_BYTES = 4
);
   logic                              rempty;
   logic [DATASIZEL-1:0]              rdata;
   logic                              rinc;
   logic                              flush;
   logic                              out_valid;
   logic                              out_ready;
   logic [DATASIZEL*WORD_BYTES-1:0]   out_data;
   logic [WORD_BYTES-1:0]             out_keep;

   modport master (
      input  rempty, rdata, flush, out_ready,
      output rinc, out_valid, out_data, out_keep
   );

   modport slave (
      output rempty, rdata, flush, out_ready,
      input  rinc, out_valid, out_data, out_keep
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-domain consumer of the asynchronous FIFO. Pops DATASIZEL-bit entries
// and packs WORD_BYTES of them little-endian into one output word, presented
// on a valid/ready stream. A flush emits a partial word with a lane-keep mask.
//
// Ports:
//   rclk      : read-domain clock (only clock)
//   rrst_n    : asynchronous active-low reset
//   io        : fifo_rd_packer_if.master (FIFO read port, flush, output stream)
//   word_cnt  : count of accepted output words, wraps modulo 2^CNTW
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
   parameter int DATASIZEL  = 8,
   parameter int WORD_BYTES = 4,
   parameter int CNTW       = 16
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   fifo_rd_packer_if.master     io,
   output logic [CNTW-1:0]      word_cnt
);

   localparam int WW   = DATASIZEL * WORD_BYTES;
   localparam int IDXW = $clog2(WORD_BYTES);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDXW-1:0]         r_idx, w_idx_nxt;
   logic [WW-1:0]           r_data, w_data_nxt;
   logic [WORD_BYTES-1:0]   r_keep, w_keep_nxt;
   logic [CNTW-1:0]         r_word_cnt;

   logic                    w_pop;
   logic                    w_last;
   logic                    w_accept;

   // Pops only in FILL; HOLD freezes the FIFO so the held word cannot grow.
   assign w_pop    = (r_state == FILL) && !io.rempty;
   assign w_last   = (r_idx == IDXW'(WORD_BYTES - 1));
   assign w_accept = (r_state == HOLD) && io.out_ready;

   // ---------------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_keep_nxt  = r_keep;

      case (r_state)
         FILL: begin
            if (w_pop) begin
               w_data_nxt[r_idx*DATASIZEL +: DATASIZEL] = io.rdata;
               w_keep_nxt[r_idx]                         = 1'b1;
               w_idx_nxt                                 = r_idx + IDXW'(1);
            end
            // A word closes when its last lane fills, or on flush provided at
            // least one lane (already filled or popped this cycle) is present;
            // a flush of an empty word is dropped.
            if ((w_pop && w_last) || (io.flush && (w_pop || (|r_keep)))) begin
               w_state_nxt = HOLD;
               w_idx_nxt   = '0;
            end
         end
         HOLD: begin
            if (io.out_ready) begin
               w_state_nxt = FILL;
               w_data_nxt  = '0;
               w_keep_nxt  = '0;
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_state    <= FILL;
         r_idx      <= '0;
         r_data     <= '0;
         r_keep     <= '0;
         r_word_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_keep  <= w_keep_nxt;
         if (w_accept) begin
            r_word_cnt <= r_word_cnt + CNTW'(1);
         end
      end
   end

   assign io.rinc      = w_pop;
   assign io.out_valid = (r_state == HOLD);
   assign io.out_data  = r_data;
   assign io.out_keep  = r_keep;
   assign word_cnt     = r_word_cnt;

endmodule
